// File: rtl/fpnew_sdotp_arbiter.sv
// rtl/fpnew_sdotp_arbiter.sv - shares one SDOTP/VSUM datapath among NumReq requesters with credits
// Define FPNEW_SDOTP_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fpnew_sdotp_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned OperandWidth   = 64,
    parameter int unsigned TagWidth       = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned NumFpFormats   = 5,
    parameter int unsigned RndModeWidth   = 3,
    parameter int unsigned OpWidth        = 4,
    parameter int unsigned FmtWidth       = 3,
    parameter int unsigned StatusWidth    = 5,
    localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned UnitTagWidth  = IdWidth + TagWidth
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NumReq-1:0]                             req_valid_i,
    output logic [NumReq-1:0]                             req_ready_o,
    input  logic [NumReq-1:0][2:0][OperandWidth-1:0]      req_operands_i,
    input  logic [NumReq-1:0][NumFpFormats-1:0][2:0]      req_is_boxed_i,
    input  logic [NumReq-1:0][RndModeWidth-1:0]           req_rnd_mode_i,
    input  logic [NumReq-1:0][OpWidth-1:0]                req_op_i,
    input  logic [NumReq-1:0]                             req_op_mod_i,
    input  logic [NumReq-1:0][FmtWidth-1:0]               req_src_fmt_i,
    input  logic [NumReq-1:0][FmtWidth-1:0]               req_dst_fmt_i,
    input  logic [NumReq-1:0][TagWidth-1:0]               req_tag_i,
    output logic [NumReq-1:0]                             rsp_valid_o,
    input  logic [NumReq-1:0]                             rsp_ready_i,
    output logic [OperandWidth-1:0]                       rsp_result_o,
    output logic [StatusWidth-1:0]                        rsp_status_o,
    output logic [TagWidth-1:0]                           rsp_tag_o,
    output logic [2:0][OperandWidth-1:0]                  unit_operands_o,
    output logic [NumFpFormats-1:0][2:0]                  unit_is_boxed_o,
    output logic [RndModeWidth-1:0]                       unit_rnd_mode_o,
    output logic [OpWidth-1:0]                            unit_op_o,
    output logic                                          unit_op_mod_o,
    output logic [FmtWidth-1:0]                           unit_src_fmt_o,
    output logic [FmtWidth-1:0]                           unit_dst_fmt_o,
    output logic [UnitTagWidth-1:0]                       unit_tag_o,
    output logic                                          unit_in_valid_o,
    input  logic                                          unit_in_ready_i,
    input  logic [OperandWidth-1:0]                       unit_result_i,
    input  logic [StatusWidth-1:0]                        unit_status_i,
    input  logic [UnitTagWidth-1:0]                       unit_tag_i,
    input  logic                                          unit_out_valid_i,
    output logic                                          unit_out_ready_o,
    input  logic                                          flush_i,
    output logic                                          unit_flush_o,
    output logic                                          busy_o
);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e                             r_state, w_state_n;
    logic [IdWidth-1:0]                 r_lock_id, w_lock_id_n;
    logic [NumReq-1:0][CntWidth-1:0]    r_cnt;
    logic [NumReq-1:0]                  w_eligible, w_inc, w_dec;
    logic                               w_arb_vld, w_grant_vld, w_in_valid, w_issue, w_retire;
    logic [IdWidth-1:0]                 w_arb_grant, w_grant, w_rsp_id;
    logic                               w_rsp_id_ok;

    function automatic logic [IdWidth-1:0] wrap_idx(input logic [IdWidth-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = int'(base) + off;
        if (sum >= NumReq) sum = sum - NumReq;
        return IdWidth'(sum);
    endfunction

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_eligible[i] = req_valid_i[i] && (r_cnt[i] < CntWidth'(MaxOutstanding));
        end
    end

`ifdef FPNEW_SDOTP_ARB_FIXED_PRIO_EN
    always_comb begin
        w_arb_vld   = 1'b0;
        w_arb_grant = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!w_arb_vld && w_eligible[k]) begin
                w_arb_vld   = 1'b1;
                w_arb_grant = IdWidth'(k);
            end
        end
    end
`else
    logic [IdWidth-1:0] r_rr_ptr;

    // Search starts at the pointer so the last winner goes to the back of the line.
    always_comb begin
        w_arb_vld   = 1'b0;
        w_arb_grant = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!w_arb_vld && w_eligible[wrap_idx(r_rr_ptr, k)]) begin
                w_arb_vld   = 1'b1;
                w_arb_grant = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= wrap_idx(w_grant, 1);
        end
    end
`endif

    always_comb begin
        w_state_n   = r_state;
        w_lock_id_n = r_lock_id;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        case (r_state)
            ST_IDLE: begin
                w_grant_vld = w_arb_vld;
                w_grant     = w_arb_grant;
                if (w_arb_vld && !unit_in_ready_i) begin
                    w_state_n   = ST_LOCKED;
                    w_lock_id_n = w_arb_grant;
                end
            end
            ST_LOCKED: begin
                w_grant_vld = 1'b1;
                w_grant     = r_lock_id;
                if (unit_in_ready_i) w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (flush_i) w_state_n = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_n;
            r_lock_id <= w_lock_id_n;
        end
    end

    assign w_in_valid      = rst_ni && w_grant_vld && !flush_i;
    assign w_issue         = w_in_valid && unit_in_ready_i;
    assign unit_in_valid_o = w_in_valid;
    assign unit_operands_o = req_operands_i[w_grant];
    assign unit_is_boxed_o = req_is_boxed_i[w_grant];
    assign unit_rnd_mode_o = req_rnd_mode_i[w_grant];
    assign unit_op_o       = req_op_i[w_grant];
    assign unit_op_mod_o   = req_op_mod_i[w_grant];
    assign unit_src_fmt_o  = req_src_fmt_i[w_grant];
    assign unit_dst_fmt_o  = req_dst_fmt_i[w_grant];
    assign unit_tag_o      = {w_grant, req_tag_i[w_grant]};
    assign unit_flush_o    = flush_i;

    always_comb begin
        req_ready_o = '0;
        if (w_in_valid) req_ready_o[w_grant] = unit_in_ready_i;
    end

    assign w_rsp_id     = unit_tag_i[UnitTagWidth-1:TagWidth];
    assign w_rsp_id_ok  = {1'b0, w_rsp_id} < (IdWidth+1)'(NumReq);
    assign rsp_result_o = unit_result_i;
    assign rsp_status_o = unit_status_i;
    assign rsp_tag_o    = unit_tag_i[TagWidth-1:0];

    always_comb begin
        rsp_valid_o      = '0;
        unit_out_ready_o = 1'b0;
        if (rst_ni && w_rsp_id_ok) begin
            rsp_valid_o[w_rsp_id] = unit_out_valid_i;
            unit_out_ready_o      = rsp_ready_i[w_rsp_id];
        end
    end

    assign w_retire = unit_out_valid_i && unit_out_ready_o;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_inc[i] = w_issue && (w_grant == IdWidth'(i));
            w_dec[i] = w_retire && (w_rsp_id == IdWidth'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CntWidth'(1);
                end else if (!w_inc[i] && w_dec[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CntWidth'(1);
                end
            end
        end
    end

    assign busy_o = rst_ni && ((r_state == ST_LOCKED) || (|r_cnt) || unit_out_valid_i);

    // Responses must belong to a real requester that has work in flight.
    a_rsp_id: assert property (@(posedge clk_i) disable iff (!rst_ni) unit_out_valid_i |-> w_rsp_id_ok);
    a_rsp_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_retire && !flush_i) |-> (r_cnt[w_rsp_id] != '0));
endmodule

// File: tb/tb_fpnew_sdotp_arbiter.sv
// tb/tb_fpnew_sdotp_arbiter.sv - self-checking bench for fpnew_sdotp_arbiter
module tb_fpnew_sdotp_arbiter;
    localparam int NR = 2, OW = 64, TW = 4, MO = 4, NF = 5, UTW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0]                req_valid = '0, req_ready;
    logic [NR-1:0][2:0][OW-1:0]   req_ops = '0;
    logic [NR-1:0][NF-1:0][2:0]   req_boxed = '0;
    logic [NR-1:0][2:0]           req_rnd = '0, req_src = '0, req_dst = '0;
    logic [NR-1:0][3:0]           req_op = '0;
    logic [NR-1:0]                req_opmod = '0;
    logic [NR-1:0][TW-1:0]        req_tag = '0;
    logic [NR-1:0]                rsp_valid, rsp_ready = '0;
    logic [OW-1:0]                rsp_result;
    logic [4:0]                   rsp_status;
    logic [TW-1:0]                rsp_tag;
    logic [2:0][OW-1:0]           unit_ops;
    logic [NF-1:0][2:0]           unit_boxed;
    logic [2:0]                   unit_rnd, unit_src, unit_dst;
    logic [3:0]                   unit_op;
    logic                         unit_opmod;
    logic [UTW-1:0]               unit_tag_o, unit_tag_i = '0;
    logic                         unit_in_valid, unit_in_ready = 1'b0;
    logic [OW-1:0]                unit_result = '0;
    logic [4:0]                   unit_status = '0;
    logic                         unit_out_valid = 1'b0, unit_out_ready;
    logic                         flush = 1'b0, unit_flush, busy;

    fpnew_sdotp_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_ops),
        .req_is_boxed_i(req_boxed), .req_rnd_mode_i(req_rnd), .req_op_i(req_op),
        .req_op_mod_i(req_opmod), .req_src_fmt_i(req_src), .req_dst_fmt_i(req_dst),
        .req_tag_i(req_tag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag),
        .unit_operands_o(unit_ops), .unit_is_boxed_o(unit_boxed), .unit_rnd_mode_o(unit_rnd),
        .unit_op_o(unit_op), .unit_op_mod_o(unit_opmod), .unit_src_fmt_o(unit_src),
        .unit_dst_fmt_o(unit_dst), .unit_tag_o(unit_tag_o), .unit_in_valid_o(unit_in_valid),
        .unit_in_ready_i(unit_in_ready), .unit_result_i(unit_result), .unit_status_i(unit_status),
        .unit_tag_i(unit_tag_i), .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
        .flush_i(flush), .unit_flush_o(unit_flush), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int m_q[$];
    int m_ptr = 0, m_lock_id = 0;
    bit m_locked = 1'b0;

    typedef struct {
        logic [UTW-1:0] tag;
        logic           ov;
        logic [NR-1:0]  rr;
        logic [NR-1:0]  exp_rv;
        logic           exp_or;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int id);
        int n = 0;
        foreach (m_q[k]) if ((m_q[k] >> TW) == id) n++;
        return n;
    endfunction

    task automatic new_req(input int i, input logic [TW-1:0] tag);
        req_valid[i] = 1'b1;
        req_tag[i]   = tag;
        req_ops[i]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_op[i]    = 4'($urandom);
        req_rnd[i]   = 3'($urandom);
        req_src[i]   = 3'($urandom);
        req_dst[i]   = 3'($urandom);
        req_opmod[i] = 1'($urandom);
        req_boxed[i] = 15'($urandom);
    endtask

    task automatic present(input bit v);
        if (v && m_q.size() > 0) begin
            unit_out_valid = 1'b1;
            unit_tag_i     = UTW'(m_q[0]);
            unit_result    = {$urandom, $urandom};
            unit_status    = 5'($urandom);
        end else begin
            unit_out_valid = 1'b0;
        end
    endtask

    // One clock: check every output against the reference, then advance the reference.
    task automatic cycle(output int g_out);
        int g, rid;
        bit ev, hs_in, hs_out;
        logic [NR-1:0] err, erv;
        #1;
        g = -1;
        if (m_locked) g = m_lock_id;
        else for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (g < 0 && req_valid[i] && cnt_of(i) < MO) g = i;
        end
        ev = (g >= 0) && !flush;
        err = '0;
        if (ev && unit_in_ready) err[g] = 1'b1;
        chk("in_valid", unit_in_valid, ev);
        chk("req_ready", req_ready, err);
        if (ev) begin
            chk("unit_tag", unit_tag_o, (g << TW) | req_tag[g]);
            chk("unit_op0", unit_ops[0], req_ops[g][0]);
            chk("unit_op2", unit_ops[2], req_ops[g][2]);
            chk("unit_op", unit_op, req_op[g]);
            chk("unit_dst", unit_dst, req_dst[g]);
        end
        rid = int'(unit_tag_i[UTW-1:TW]);
        erv = '0;
        if (unit_out_valid) erv[rid] = 1'b1;
        chk("rsp_valid", rsp_valid, erv);
        chk("out_ready", unit_out_ready, rsp_ready[rid]);
        if (unit_out_valid) begin
            chk("rsp_tag", rsp_tag, unit_tag_i[TW-1:0]);
            chk("rsp_result", rsp_result, unit_result);
        end
        chk("busy", busy, m_locked || m_q.size() != 0 || unit_out_valid);
        chk("unit_flush", unit_flush, flush);
        hs_in  = ev && unit_in_ready;
        hs_out = unit_out_valid && rsp_ready[rid];
        g_out  = hs_in ? g : -1;
        @(posedge clk);
        if (flush) begin
            m_q.delete();
            m_locked = 1'b0;
        end else begin
            if (hs_out) begin
                for (int k = 0; k < m_q.size(); k++) begin
                    if ((m_q[k] >> TW) == rid) begin
                        m_q.delete(k);
                        break;
                    end
                end
            end
            if (hs_in) begin
                m_q.push_back((g << TW) | req_tag[g]);
`ifndef FPNEW_SDOTP_ARB_FIXED_PRIO_EN
                m_ptr = (g + 1) % NR;
`endif
                m_locked = 1'b0;
            end else if (g >= 0 && !unit_in_ready) begin
                m_locked  = 1'b1;
                m_lock_id = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        req_valid     = '0;
        flush         = 1'b0;
        rsp_ready     = '1;
        unit_in_ready = 1'b1;
        for (int n = 0; n < 40 && (m_q.size() != 0 || m_locked); n++) begin
            present(1'b1);
            cycle(g);
        end
        unit_out_valid = 1'b0;
        #1;
        chk("drain_busy", busy, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int exp_alt[10];
`ifdef FPNEW_SDOTP_ARB_FIXED_PRIO_EN
        exp_alt = '{0, 0, 0, 0, 1, 1, 1, 1, -1, -1};
`else
        exp_alt = '{0, 1, 0, 1, 0, 1, 0, 1, -1, -1};
`endif
        tbl[0] = '{5'h1A, 1'b1, 2'b01, 2'b10, 1'b0};
        tbl[1] = '{5'h1A, 1'b1, 2'b10, 2'b10, 1'b1};
        tbl[2] = '{5'h03, 1'b1, 2'b01, 2'b01, 1'b1};
        tbl[3] = '{5'h03, 1'b1, 2'b10, 2'b01, 1'b0};
        tbl[4] = '{5'h0F, 1'b0, 2'b11, 2'b00, 1'b1};
        tbl[5] = '{5'h15, 1'b0, 2'b00, 2'b00, 1'b0};

        // reset with active-looking inputs
        req_valid = 2'b11; unit_in_ready = 1'b1; unit_out_valid = 1'b1; rsp_ready = 2'b11;
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_in_valid", unit_in_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        req_valid = '0; unit_out_valid = 1'b0; rsp_ready = '0; unit_in_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // response routing vectors (state idle)
        for (int v = 0; v < 6; v++) begin
            unit_tag_i = tbl[v].tag; unit_out_valid = tbl[v].ov; rsp_ready = tbl[v].rr;
            #1;
            chk("tbl_rsp_valid", rsp_valid, tbl[v].exp_rv);
            chk("tbl_out_ready", unit_out_ready, tbl[v].exp_or);
            chk("tbl_rsp_tag", rsp_tag, tbl[v].tag[TW-1:0]);
            chk("tbl_busy", busy, tbl[v].ov);
            unit_out_valid = 1'b0;
            @(negedge clk);
        end
        rsp_ready = '0;

        // both requesters streaming, credits run out
        unit_in_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            new_req(0, 4'(c)); new_req(1, 4'(c + 8));
            cycle(g);
            chk("alt_grant", g, exp_alt[c]);
        end
        drain();

        // lock holds grant and payload while the datapath stalls
        unit_in_ready = 1'b0;
        new_req(0, 4'h3);
        req_ops[0][0] = 64'h0123_4567_89AB_CDEF;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) new_req(1, 4'h7);
            #1;
            chk("lock_tag", unit_tag_o, 5'h03);
            chk("lock_op0", unit_ops[0], 64'h0123_4567_89AB_CDEF);
            cycle(g);
        end
        unit_in_ready = 1'b1;
        cycle(g);
        chk("lock_release_grant", g, 0);
        req_valid[0] = 1'b0;
        cycle(g);
        chk("lock_next_grant", g, 1);
        drain();

        // response for requester 1 blocked until its ready rises
        new_req(1, 4'hA); req_valid[0] = 1'b0;
        cycle(g);
        req_valid = '0;
        present(1'b1); rsp_ready = 2'b01;
        #1;
        chk("stall_rsp_valid", rsp_valid, 2'b10);
        chk("stall_out_ready", unit_out_ready, 1'b0);
        cycle(g);
        rsp_ready = 2'b11;
        #1;
        chk("stall_rsp_tag", rsp_tag, 4'hA);
        chk("stall_out_ready_hi", unit_out_ready, 1'b1);
        cycle(g);
        unit_out_valid = 1'b0;
        #1;
        chk("stall_busy_after", busy, 1'b0);
        @(negedge clk);

        // same-cycle issue and retire, and credit limit
        rsp_ready = 2'b11;
        for (int c = 0; c < 2; c++) begin new_req(0, 4'(c)); cycle(g); end
        new_req(0, 4'h2); present(1'b1);
        cycle(g);
        chk("same_cycle_issue", g, 0);
        unit_out_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin new_req(0, 4'(c + 3)); cycle(g); end
        new_req(0, 4'h5); present(1'b1);
        #1;
        chk("full_ready", req_ready, 2'b00);
        chk("full_in_valid", unit_in_valid, 1'b0);
        cycle(g);
        unit_out_valid = 1'b0;
        #1;
        chk("refill_ready", req_ready, 2'b01);
        cycle(g);
        drain();

        // flush with three ops in flight
        for (int c = 0; c < 3; c++) begin new_req(0, 4'(c)); new_req(1, 4'(c)); cycle(g); end
        flush = 1'b1;
        #1;
        chk("flush_unit_flush", unit_flush, 1'b1);
        chk("flush_in_valid", unit_in_valid, 1'b0);
        chk("flush_req_ready", req_ready, 2'b00);
        cycle(g);
        flush = 1'b0; req_valid = '0; unit_out_valid = 1'b0;
        #1;
        chk("flush_busy", busy, 1'b0);
        cycle(g);

        // randomized traffic against the reference
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) new_req(i, 4'($urandom));
            end
            unit_in_ready = ($urandom_range(0, 3) != 0);
            rsp_ready     = 2'($urandom);
            flush         = ($urandom_range(0, 49) == 0);
            present($urandom_range(0, 1) == 1);
            cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        flush = 1'b0;

        // asynchronous reset mid-operation
        new_req(0, 4'h1); new_req(1, 4'h2); unit_in_ready = 1'b1;
        cycle(g);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_valid", unit_in_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 2'b00);
        m_q.delete(); m_ptr = 0; m_locked = 1'b0;
        unit_out_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b10;
        cycle(g);
        chk("post_rst_grant", g, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
